// File: rtl/vga_multiball.sv
// vga_multiball: Avalon-MM slave that draws up to NUM_BALLS filled circles
// over a programmable background on a 640x480 VGA output.
//
// Ports:
//   clk, reset              50 MHz clock, synchronous active-high reset
//   writedata/write/read/   Avalon byte-wide register port; readdata has a
//   chipselect/address      read latency of 1 and holds between reads
//   readdata                registered read data
//   irq                     level interrupt, set at frame commit when enabled
//   VGA_R/G/B               pixel colour (2-clk pipeline behind the counters)
//   VGA_CLK/HS/VS/BLANK_n   timing outputs, aligned with the colour
//   VGA_SYNC_n              tied low
//
// Register map (byte addresses): ball i at 8*i: x lo, x hi, y lo, y hi,
// radius, R, G, B. Globals at G = 8*NUM_BALLS: bg R, bg G, bg B, enable
// mask, control {irq_pending,6'b0,irq_en}, frame counter (read-only).
// Writes land in the pending bank; the active bank is loaded from it once
// per frame at the last pixel of the last visible line.
//
// The H_*/V_* parameters default to standard 640x480 timing.
module vga_multiball #(
  parameter int unsigned NUM_BALLS    = 4,
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned H_ACTIVE     = 1280,
  parameter int unsigned H_SYNC_START = 1312,
  parameter int unsigned H_SYNC_END   = 1503,
  parameter int unsigned H_TOTAL      = 1600,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_SYNC_START = 490,
  parameter int unsigned V_SYNC_END   = 491,
  parameter int unsigned V_TOTAL      = 525
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        writedata,
  input  logic              write,
  input  logic              read,
  input  logic              chipselect,
  input  logic [ADDR_W-1:0] address,
  output logic [7:0]        readdata,
  output logic              irq,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_n,
  output logic              VGA_SYNC_n
);

  localparam logic [10:0] LP_HA   = 11'(H_ACTIVE);
  localparam logic [10:0] LP_HSS  = 11'(H_SYNC_START);
  localparam logic [10:0] LP_HSE  = 11'(H_SYNC_END);
  localparam logic [10:0] LP_HL   = 11'(H_TOTAL - 1);
  localparam logic [9:0]  LP_VA   = 10'(V_ACTIVE);
  localparam logic [9:0]  LP_VSS  = 10'(V_SYNC_START);
  localparam logic [9:0]  LP_VSE  = 10'(V_SYNC_END);
  localparam logic [9:0]  LP_VL   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  LP_VAL  = 10'(V_ACTIVE - 1);
  localparam logic [ADDR_W-4:0] LP_GBLK = (ADDR_W-3)'(NUM_BALLS);

  // timing counters
  logic [10:0] r_hcount;
  logic [9:0]  r_vcount;
  logic        w_h_end;
  logic        w_commit;

  assign w_h_end  = (r_hcount == LP_HL);
  assign w_commit = w_h_end && (r_vcount == LP_VAL);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (w_h_end) begin
      r_hcount <= '0;
      r_vcount <= (r_vcount == LP_VL) ? '0 : r_vcount + 10'd1;
    end else begin
      r_hcount <= r_hcount + 11'd1;
    end
  end

  // pending (p) and active (a) register banks
  logic [9:0] r_p_x   [NUM_BALLS];
  logic [9:0] r_p_y   [NUM_BALLS];
  logic [7:0] r_p_rad [NUM_BALLS];
  logic [7:0] r_p_cr  [NUM_BALLS];
  logic [7:0] r_p_cg  [NUM_BALLS];
  logic [7:0] r_p_cb  [NUM_BALLS];
  logic [9:0] r_a_x   [NUM_BALLS];
  logic [9:0] r_a_y   [NUM_BALLS];
  logic [7:0] r_a_rad [NUM_BALLS];
  logic [7:0] r_a_cr  [NUM_BALLS];
  logic [7:0] r_a_cg  [NUM_BALLS];
  logic [7:0] r_a_cb  [NUM_BALLS];
  logic [7:0] r_p_bg_r, r_p_bg_g, r_p_bg_b;
  logic [7:0] r_a_bg_r, r_a_bg_g, r_a_bg_b;
  logic [NUM_BALLS-1:0] r_p_en, r_a_en;
  logic       r_irq_en;
  logic       r_irq_pending;
  logic [7:0] r_frame;

  logic              w_wr, w_rd, w_glob;
  logic [ADDR_W-4:0] w_blk;
  logic [2:0]        w_sub;

  assign w_wr   = chipselect && write;
  assign w_rd   = chipselect && read;
  assign w_blk  = address[ADDR_W-1:3];
  assign w_sub  = address[2:0];
  assign w_glob = (w_blk == LP_GBLK);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_BALLS; i++) begin
        r_p_x[i]   <= (i == 0) ? 10'd30 : '0;
        r_p_y[i]   <= (i == 0) ? 10'd30 : '0;
        r_p_rad[i] <= (i == 0) ? 8'd16  : '0;
        r_p_cr[i]  <= (i == 0) ? 8'hE3  : '0;
        r_p_cg[i]  <= (i == 0) ? 8'h41  : '0;
        r_p_cb[i]  <= (i == 0) ? 8'hDC  : '0;
        r_a_x[i]   <= (i == 0) ? 10'd30 : '0;
        r_a_y[i]   <= (i == 0) ? 10'd30 : '0;
        r_a_rad[i] <= (i == 0) ? 8'd16  : '0;
        r_a_cr[i]  <= (i == 0) ? 8'hE3  : '0;
        r_a_cg[i]  <= (i == 0) ? 8'h41  : '0;
        r_a_cb[i]  <= (i == 0) ? 8'hDC  : '0;
      end
      r_p_bg_r      <= 8'h00;
      r_p_bg_g      <= 8'h99;
      r_p_bg_b      <= 8'h60;
      r_a_bg_r      <= 8'h00;
      r_a_bg_g      <= 8'h99;
      r_a_bg_b      <= 8'h60;
      r_p_en        <= NUM_BALLS'(1);
      r_a_en        <= NUM_BALLS'(1);
      r_irq_en      <= 1'b0;
      r_irq_pending <= 1'b0;
      r_frame       <= '0;
    end else begin
      if (w_wr) begin
        for (int unsigned i = 0; i < NUM_BALLS; i++) begin
          if (w_blk == (ADDR_W-3)'(i)) begin
            case (w_sub)
              3'd0: r_p_x[i][7:0]  <= writedata;
              3'd1: r_p_x[i][9:8]  <= writedata[1:0];
              3'd2: r_p_y[i][7:0]  <= writedata;
              3'd3: r_p_y[i][9:8]  <= writedata[1:0];
              3'd4: r_p_rad[i]     <= writedata;
              3'd5: r_p_cr[i]      <= writedata;
              3'd6: r_p_cg[i]      <= writedata;
              default: r_p_cb[i]   <= writedata;
            endcase
          end
        end
        if (w_glob) begin
          case (w_sub)
            3'd0: r_p_bg_r <= writedata;
            3'd1: r_p_bg_g <= writedata;
            3'd2: r_p_bg_b <= writedata;
            3'd3: r_p_en   <= writedata[NUM_BALLS-1:0];
            3'd4: begin
              r_irq_en      <= writedata[0];
              r_irq_pending <= 1'b0;
            end
            default: ;
          endcase
        end
      end
      // Commit samples pre-write pending values; a same-cycle write lands
      // next frame. The irq set is placed last so it wins over a clear.
      if (w_commit) begin
        r_a_x    <= r_p_x;
        r_a_y    <= r_p_y;
        r_a_rad  <= r_p_rad;
        r_a_cr   <= r_p_cr;
        r_a_cg   <= r_p_cg;
        r_a_cb   <= r_p_cb;
        r_a_bg_r <= r_p_bg_r;
        r_a_bg_g <= r_p_bg_g;
        r_a_bg_b <= r_p_bg_b;
        r_a_en   <= r_p_en;
        r_frame  <= r_frame + 8'd1;
        if (r_irq_en) r_irq_pending <= 1'b1;
      end
    end
  end

  // readback of the pending bank
  logic [7:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    for (int unsigned i = 0; i < NUM_BALLS; i++) begin
      if (w_blk == (ADDR_W-3)'(i)) begin
        case (w_sub)
          3'd0: w_rdata = r_p_x[i][7:0];
          3'd1: w_rdata = {6'b0, r_p_x[i][9:8]};
          3'd2: w_rdata = r_p_y[i][7:0];
          3'd3: w_rdata = {6'b0, r_p_y[i][9:8]};
          3'd4: w_rdata = r_p_rad[i];
          3'd5: w_rdata = r_p_cr[i];
          3'd6: w_rdata = r_p_cg[i];
          default: w_rdata = r_p_cb[i];
        endcase
      end
    end
    if (w_glob) begin
      case (w_sub)
        3'd0: w_rdata = r_p_bg_r;
        3'd1: w_rdata = r_p_bg_g;
        3'd2: w_rdata = r_p_bg_b;
        3'd3: w_rdata = 8'(r_p_en);
        3'd4: w_rdata = {r_irq_pending, 6'b0, r_irq_en};
        3'd5: w_rdata = r_frame;
        default: w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)     readdata <= '0;
    else if (w_rd) readdata <= w_rdata;
  end

  assign irq        = r_irq_pending;
  assign VGA_SYNC_n = 1'b0;

  // circle hit test: unsigned coordinates, signed 11-bit deltas, strict <
  function automatic logic ball_hit(input logic [9:0] col, input logic [9:0] row,
                                    input logic [9:0] bx, input logic [9:0] by,
                                    input logic [7:0] rad);
    logic signed [10:0] dx11, dy11;
    logic signed [21:0] dx, dy;
    logic [21:0] d2, r2;
    dx11 = $signed({1'b0, col}) - $signed({1'b0, bx});
    dy11 = $signed({1'b0, row}) - $signed({1'b0, by});
    dx   = {{11{dx11[10]}}, dx11};
    dy   = {{11{dy11[10]}}, dy11};
    d2   = dx * dx + dy * dy;
    r2   = {14'b0, rad} * {14'b0, rad};
    return d2 < r2;
  endfunction

  // stage 1: hit flags and timing
  logic [NUM_BALLS-1:0] w_hit, r_hit1;
  logic w_hs, w_vs, w_blank_n;
  logic r_hs1, r_vs1, r_blank1, r_clk1;

  always_comb begin
    w_hit = '0;
    for (int unsigned i = 0; i < NUM_BALLS; i++) begin
      w_hit[i] = r_a_en[i] &&
                 ball_hit(r_hcount[10:1], r_vcount, r_a_x[i], r_a_y[i], r_a_rad[i]);
    end
    w_hs      = !((r_hcount >= LP_HSS) && (r_hcount <= LP_HSE));
    w_vs      = !((r_vcount >= LP_VSS) && (r_vcount <= LP_VSE));
    w_blank_n = (r_hcount < LP_HA) && (r_vcount < LP_VA);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit1   <= '0;
      r_hs1    <= 1'b1;
      r_vs1    <= 1'b1;
      r_blank1 <= 1'b0;
      r_clk1   <= 1'b0;
    end else begin
      r_hit1   <= w_hit;
      r_hs1    <= w_hs;
      r_vs1    <= w_vs;
      r_blank1 <= w_blank_n;
      r_clk1   <= r_hcount[0];
    end
  end

  // stage 2: colour select, lowest enabled hitting ball wins
  logic [23:0] w_pix;
  logic        w_found;

  always_comb begin
    w_pix   = {r_a_bg_r, r_a_bg_g, r_a_bg_b};
    w_found = 1'b0;
    for (int unsigned i = 0; i < NUM_BALLS; i++) begin
      if (!w_found && r_hit1[i]) begin
        w_pix   = {r_a_cr[i], r_a_cg[i], r_a_cb[i]};
        w_found = 1'b1;
      end
    end
    if (!r_blank1) w_pix = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_n <= 1'b0;
      VGA_CLK     <= 1'b0;
    end else begin
      {VGA_R, VGA_G, VGA_B} <= w_pix;
      VGA_HS      <= r_hs1;
      VGA_VS      <= r_vs1;
      VGA_BLANK_n <= r_blank1;
      VGA_CLK     <= r_clk1;
    end
  end

endmodule

// File: tb/tb_vga_multiball.sv
// Directed bench for vga_multiball using a shortened raster so that several
// frames fit in a short run. Pixel (c,r) appears on the outputs two clocks
// after the counters reach hcount=2c, vcount=r.
module tb_vga_multiball;

  localparam int unsigned NB  = 4;
  localparam int unsigned AW  = 6;
  localparam int unsigned HA  = 160;
  localparam int unsigned HSS = 168;
  localparam int unsigned HSE = 183;
  localparam int unsigned HT  = 200;
  localparam int unsigned VA  = 48;
  localparam int unsigned VSS = 50;
  localparam int unsigned VSE = 51;
  localparam int unsigned VT  = 54;
  localparam int unsigned G   = 8 * NB;

  localparam logic [23:0] C_BALL0 = 24'hE341DC;
  localparam logic [23:0] C_BG    = 24'h009960;
  localparam logic [23:0] C_WHITE = 24'hFFFFFF;

  logic          clk;
  logic          reset;
  logic [7:0]    writedata;
  logic          write;
  logic          read;
  logic          chipselect;
  logic [AW-1:0] address;
  logic [7:0]    readdata;
  logic          irq;
  logic [7:0]    VGA_R, VGA_G, VGA_B;
  logic          VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n;

  int checks   = 0;
  int failures = 0;

  vga_multiball #(
    .NUM_BALLS(NB), .ADDR_W(AW),
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .reset(reset), .writedata(writedata), .write(write),
    .read(read), .chipselect(chipselect), .address(address),
    .readdata(readdata), .irq(irq),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_CLK(VGA_CLK),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n),
    .VGA_SYNC_n(VGA_SYNC_n)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // bench-side raster position, advanced from the same reset
  int unsigned mh, mv;
  always @(posedge clk) begin
    if (reset) begin
      mh <= 0;
      mv <= 0;
    end else if (mh == HT - 1) begin
      mh <= 0;
      mv <= (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh <= mh + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int unsigned h, input int unsigned v);
    int unsigned n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(mh == h && mv == v) && n < 3 * HT * VT);
    check("goto_reached", {31'b0, (mh == h && mv == v)}, 32'd1);
  endtask

  task automatic wr(input int unsigned a, input logic [7:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = AW'(a);
    writedata  = d;
    step();
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic rd(input int unsigned a, input logic [7:0] exp, input string tag);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = AW'(a);
    step();
    chipselect = 1'b0;
    read       = 1'b0;
    check(tag, {24'b0, readdata}, {24'b0, exp});
  endtask

  task automatic pix(input int unsigned col, input int unsigned row,
                     input logic [23:0] exp, input string tag);
    goto(2 * col + 2, row);
    check(tag, {8'b0, VGA_R, VGA_G, VGA_B}, {8'b0, exp});
  endtask

  initial begin
    reset      = 1'b1;
    writedata  = '0;
    write      = 1'b0;
    read       = 1'b0;
    chipselect = 1'b0;
    address    = '0;
    repeat (3) step();

    // reset state
    check("rst_readdata", {24'b0, readdata}, 32'h0);
    check("rst_rgb", {8'b0, VGA_R, VGA_G, VGA_B}, 32'h0);
    check("rst_hs", {31'b0, VGA_HS}, 32'd1);
    check("rst_vs", {31'b0, VGA_VS}, 32'd1);
    check("rst_blank_n", {31'b0, VGA_BLANK_n}, 32'd0);
    check("rst_vga_clk", {31'b0, VGA_CLK}, 32'd0);
    check("rst_sync_n", {31'b0, VGA_SYNC_n}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    reset = 1'b0;

    // frame 0: register readback of reset values
    rd(0, 8'h1E, "rd_b0_xlo");
    rd(1, 8'h00, "rd_b0_xhi");
    rd(2, 8'h1E, "rd_b0_ylo");
    rd(4, 8'h10, "rd_b0_rad");
    rd(7, 8'hDC, "rd_b0_b");
    rd(8, 8'h00, "rd_b1_xlo");
    rd(G + 1, 8'h99, "rd_bg_g");
    rd(G + 2, 8'h60, "rd_bg_b");
    rd(G + 3, 8'h01, "rd_enable");
    rd(G + 4, 8'h00, "rd_ctrl");
    rd(G + 5, 8'h00, "rd_frame0");
    rd(G + 6, 8'h00, "rd_unmapped");
    rd(63, 8'h00, "rd_unmapped_top");
    rd(5, 8'hE3, "rd_b0_r");
    step();
    step();
    check("rd_hold", {24'b0, readdata}, 32'h0000_00E3);
    wr(G + 5, 8'h55);
    rd(G + 5, 8'h00, "rd_frame_ro");

    // frame 0: reset ball, radius boundary
    pix(30, 14, C_BG,    "px_top_edge_out");
    pix(30, 15, C_BALL0, "px_top_edge_in");
    pix(30, 30, C_BALL0, "px_centre");
    pix(45, 30, C_BALL0, "px_right_in");
    pix(46, 30, C_BG,    "px_right_out");

    // pipeline latency of timing outputs
    goto(HA + 1, 31);
    check("blank_before", {31'b0, VGA_BLANK_n}, 32'd1);
    step();
    check("blank_after", {31'b0, VGA_BLANK_n}, 32'd0);
    check("blank_rgb_zero", {8'b0, VGA_R, VGA_G, VGA_B}, 32'h0);
    check("vga_clk_even", {31'b0, VGA_CLK}, 32'd0);
    step();
    check("vga_clk_odd", {31'b0, VGA_CLK}, 32'd1);
    goto(HSS + 1, 31);
    check("hs_before", {31'b0, VGA_HS}, 32'd1);
    step();
    check("hs_low", {31'b0, VGA_HS}, 32'd0);
    goto(HSE + 2, 31);
    check("hs_end_low", {31'b0, VGA_HS}, 32'd0);
    step();
    check("hs_end_high", {31'b0, VGA_HS}, 32'd1);

    // mid-frame move of ball 0 to x=60 does not affect this frame
    goto(10, 35);
    wr(0, 8'h3C);
    wr(1, 8'h00);
    rd(0, 8'h3C, "rd_pending_x");
    pix(30, 40, C_BALL0, "px_cur_frame_unchanged");
    goto(2, VSS - 1);
    check("vs_before", {31'b0, VGA_VS}, 32'd1);
    goto(2, VSS);
    check("vs_low", {31'b0, VGA_VS}, 32'd0);
    goto(2, VSE + 1);
    check("vs_after", {31'b0, VGA_VS}, 32'd1);

    // frame 1: moved ball, frame counter, no irq while disabled
    goto(2, 0);
    check("irq_disabled", {31'b0, irq}, 32'd0);
    rd(G + 5, 8'h01, "rd_frame1");
    pix(30, 30, C_BG,    "px_old_pos_gone");
    pix(60, 30, C_BALL0, "px_new_pos");

    // ball 1 concentric with ball 0, white, radius 10
    goto(10, 35);
    wr(8, 8'd60);
    wr(10, 8'd30);
    wr(12, 8'd10);
    wr(13, 8'hFF);
    wr(14, 8'hFF);
    wr(15, 8'hFF);
    wr(G + 3, 8'hF3);
    rd(G + 3, 8'h03, "rd_enable_masked");

    // frame 2: overlap resolves to ball 0
    pix(60, 25, C_BALL0, "px_overlap_a");
    pix(60, 30, C_BALL0, "px_overlap_b");
    goto(10, 35);
    wr(G + 3, 8'h02);
    wr(G + 4, 8'h01);
    rd(G + 4, 8'h01, "rd_irq_en");

    // irq at the commit ending frame 2
    goto(HT - 1, VA - 1);
    check("irq_pre_commit", {31'b0, irq}, 32'd0);
    step();
    check("irq_rise", {31'b0, irq}, 32'd1);
    rd(G + 4, 8'h81, "rd_ctrl_pending");
    wr(G + 4, 8'h01);
    check("irq_clear", {31'b0, irq}, 32'd0);

    // frame 3: ball 0 disabled, ball 1 visible
    rd(G + 5, 8'h03, "rd_frame3");
    pix(60, 15, C_BG,    "px_ball0_masked");
    pix(60, 30, C_WHITE, "px_ball1_visible");

    // write exactly on the commit cycle ending frame 3
    goto(HT - 1, VA - 1);
    wr(13, 8'h00);
    rd(13, 8'h00, "rd_commit_cycle_pending");
    pix(60, 30, C_WHITE, "px_commit_write_absent");
    pix(60, 30, 24'h00FFFF, "px_commit_write_present");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_multiball.md
# vga_multiball

Parametrised successor to the single-ball VGA peripheral: an Avalon memory-mapped slave that draws up to `NUM_BALLS` independently positioned, sized and coloured filled circles over a programmable background on a 640x480 VGA output. Register writes land in a pending bank and are copied to the active bank once per frame at the start of vertical blanking, so there is no mid-frame tearing. The block provides a frame counter, a per-frame interrupt, registered readback, and a pipelined pixel path. It sits on the lightweight HPS-to-FPGA bridge and drives the board VGA DAC directly.

## Interface
- NUM_BALLS, 4, number of balls, 1..8
- ADDR_W, 6, address width; must satisfy NUM_BALLS*8+8 <= 2^ADDR_W
- clk  in  1  50 MHz system clock
- reset  in  1  synchronous, active-high
- writedata  in  8  Avalon write data
- write  in  1  Avalon write strobe
- read  in  1  Avalon read strobe
- chipselect  in  1  Avalon chip select
- address  in  ADDR_W  byte register index
- readdata  out  8  Avalon read data, read latency 1
- irq  out  1  frame-commit interrupt, level
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour
- VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n  out  1 each  VGA timing

## Operation
- Internal counters: hcount 0..1599 (pixel column = hcount[10:1]) and vcount 0..524. Standard 640x480 timing: HS low for hcount 1312..1503; VS low for vcount 490..491; BLANK_n high only when hcount<1280 and vcount<480; VGA_CLK = hcount[0]; SYNC_n = 0.
- Per-ball registers, at base 8*i: +0 x[7:0]; +1 x[9:8] (writedata[1:0]); +2 y[7:0]; +3 y[9:8]; +4 radius[7:0]; +5 R; +6 G; +7 B.
- Global registers, at base G = 8*NUM_BALLS:
  - G+0/1/2: background R/G/B.
  - G+3: enable mask, bit i enables ball i. Bits >= NUM_BALLS are ignored and read 0.
  - G+4: control. Bit 0 = irq_en. Any write clears irq_pending. Reads return {irq_pending, 6'b0, irq_en}.
  - G+5: frame counter, 8 bits, read-only, wraps 255 -> 0.
  - Writes to read-only or unmapped addresses are ignored; reads of unmapped addresses return 0x00.
- Writes (chipselect && write) update the pending bank only. Reads (chipselect && read) return the pending bank.
- Commit occurs on the cycle where hcount==1599 and vcount==479:
  - active bank <= pending bank;
  - frame counter +1;
  - irq_pending <= 1 if irq_en.
- A write in the same cycle as commit updates pending only. The committed value is the pre-write pending value, so the write takes effect at the next commit.
- Hit test for ball i uses unsigned 10-bit x, y and column/row, evaluated at each 50 MHz cycle: dx = col - x and dy = row - y as 11-bit signed; dx^2 + dy^2 computed at 22 bits; hit when (dx^2 + dy^2) < radius^2, which is strict. Radius 0 never hits. Balls partly or wholly off-screen are clipped, with no wrap-around.
- Colour select: when BLANK_n is high, use the lowest-index enabled ball that hits, else the background. When BLANK_n is low, output 0x000000.
- irq = irq_pending.

## Timing
- Pixel pipeline is 2 clk:
  - stage 1 registers the per-ball hit flags together with delayed copies of the HS/VS/BLANK_n/VGA_CLK timing;
  - stage 2 registers VGA_R/G/B and the aligned timing outputs.
  - All VGA outputs therefore lag the counters by exactly 2 clk and stay mutually aligned.
- readdata is valid the cycle after the read strobe. Without a read it holds its last value.
- Reset values:
  - hcount, vcount = 0; frame counter = 0; irq_en = 0; irq_pending = 0; readdata = 0x00.
  - VGA_R/G/B = 0, VGA_HS = 1, VGA_VS = 1, VGA_BLANK_n = 0, VGA_CLK = 0, VGA_SYNC_n = 0.
  - Background = (0x00, 0x99, 0x60), in both banks.
  - Ball 0 = x 30, y 30, radius 16, colour (0xE3, 0x41, 0xDC), enabled. Balls 1..N-1 = all fields 0, disabled. Both banks hold these values.
- Reset asserted mid-frame restarts timing at hcount 0 / vcount 0 on the next cycle and discards any uncommitted writes.

## Test plan
- Reset, then sample pixel (30,30) -> colour E3/41/DC. Pixel (46,30) -> background 00/99/60, since 16^2 is not < 16^2. Pixel (45,30) -> E3/41/DC.
- Write ball 0 x = 0x12C (300) mid-frame (vcount 200) -> pixels of the current frame are unchanged; the next frame shows the ball centred at column 300; frame counter increments by 1 per frame.
- Enable balls 0 and 1 at the same centre (100,100) with ball 1 colour FF/FF/FF -> overlap shows ball 0 colour; disable ball 0 -> ball 1 colour appears after the next commit.
- Set irq_en = 1 -> irq rises on the cycle after hcount 1599 / vcount 479; a write to G+4 deasserts it the next cycle; a read of G+4 before that write returns 0x81.
- Issue a write on the exact commit cycle -> the new value is absent in the following frame and present in the one after.
- Check the 2-clk latency: VGA_BLANK_n falls exactly 2 clk after hcount reaches 1280, and VGA_HS goes low 2 clk after hcount reaches 1312.
